// File: rtl/ambtc_pkg.sv
// Shared types and helpers for the AMBTC block coder: FSM states, width
// helpers, grayscale conversion and pixel-range clamping.
package ambtc_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_MEAN,
        S_DEV,
        S_DIV_L,
        S_DIV_H,
        S_WRITE,
        S_NEXT,
        S_FIN
    } state_e;

    // Accumulator / divider width: a full tile sum of PIX_W-bit pixels.
    function automatic int num_w(input int pix_w, input int blk_log2);
        return pix_w + 2 * blk_log2;
    endfunction

    function automatic int gray(input int r, input int g, input int b);
        int mx;
        int mn;
        mx = r;
        mn = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        if (g < mn) mn = g;
        if (b < mn) mn = b;
        return (mx + mn) >> 1;
    endfunction

    function automatic int clamp(input int v, input int pix_w);
        int hi;
        hi = (1 << pix_w) - 1;
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/ambtc_seq_div.sv
// Restoring unsigned divider: one load cycle, then one quotient bit per cycle.
module ambtc_seq_div #(
    parameter int NUM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [NUM_W-1:0] divisor,
    output logic [NUM_W-1:0] quot,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] rem;
    logic [NUM_W-1:0] q;
    logic [NUM_W-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [NUM_W:0]   trial;
    logic             fits;

    assign trial = {rem, q[NUM_W-1]};
    assign fits  = trial >= {1'b0, dvs};
    assign quot  = q;
    // start is honoured only while idle; done marks the cycle whose closing
    // edge produces the last quotient bit, so quot is final from the next cycle.
    assign done  = busy && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            q    <= '0;
            dvs  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start && !busy) begin
            rem  <= '0;
            q    <= dividend;
            dvs  <= divisor;
            cnt  <= CW'(NUM_W);
            busy <= 1'b1;
        end else if (busy) begin
            rem  <= fits ? NUM_W'(trial - {1'b0, dvs}) : trial[NUM_W-1:0];
            q    <= {q[NUM_W-2:0], fits};
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/ambtc_block_coder.sv
// AMBTC compressor: walks the image tile by tile, computes mean/deviation
// levels and writes the two-level reconstruction back over the pixel bus.
module ambtc_block_coder
    import ambtc_pkg::*;
#(
    parameter int IMG_LOG2 = 6,
    parameter int BLK_LOG2 = 2,
    parameter int PIX_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [3*PIX_W-1:0]    in_pix,
    output logic [IMG_LOG2-1:0]   row,
    output logic [IMG_LOG2-1:0]   col,
    output logic                  out_we,
    output logic [3*PIX_W-1:0]    out_pix,
    output logic                  busy,
    output logic                  done,
    output state_e                state_dbg
);
    localparam int N  = 1 << (2 * BLK_LOG2);
    localparam int NW = num_w(PIX_W, BLK_LOG2);
    localparam int IW = 2 * BLK_LOG2 + 1;
    localparam int TW = IMG_LOG2 - BLK_LOG2;

    state_e            state, state_nx;
    logic [TW-1:0]     tile_r, tile_c;
    logic [IW-1:0]     idx, idx_m1, beta, beta_next, n_minus_beta;
    logic              mode_q, uniform;
    logic [PIX_W-1:0]  tile_buf [N];
    logic [NW-1:0]     sum, acc;
    logic [PIX_W-1:0]  avg, lm, hm, level;
    logic [PIX_W-1:0]  r_ch, g_ch, b_ch, pix_val, cur_pix, abs_diff;
    logic              cur_ge, last_tile;
    logic              div_start, div_busy, div_done;
    logic [NW-1:0]     div_num, div_den, quot;
    logic signed [NW:0] lm_pre, hm_pre;

    assign r_ch    = in_pix[3*PIX_W-1:2*PIX_W];
    assign g_ch    = in_pix[2*PIX_W-1:PIX_W];
    assign b_ch    = in_pix[PIX_W-1:0];
    assign pix_val = mode_q ? PIX_W'(gray(int'(r_ch), int'(g_ch), int'(b_ch))) : g_ch;

    assign idx_m1    = idx - IW'(1);
    assign cur_pix   = tile_buf[idx[IW-2:0]];
    assign cur_ge    = cur_pix >= avg;
    assign abs_diff  = cur_ge ? cur_pix - avg : avg - cur_pix;
    assign beta_next = beta + IW'(cur_ge);
    assign last_tile = (tile_r == '1) && (tile_c == '1);

    // Numerator is N*var, i.e. the deviation sum with its fraction bits dropped.
    assign n_minus_beta = IW'(N) - beta;
    assign div_num = {acc[NW-1:2*BLK_LOG2], {(2*BLK_LOG2){1'b0}}};
    assign div_den = (state == S_DIV_L) ? NW'({n_minus_beta, 1'b0}) : NW'({beta, 1'b0});

    assign lm_pre = $signed({1'b0, NW'(avg)}) - $signed({1'b0, quot});
    assign hm_pre = $signed({1'b0, NW'(avg)}) + $signed({1'b0, quot});
    // Hm's quotient stays parked in the divider for the whole WRITE phase.
    assign hm     = uniform ? avg : PIX_W'(clamp(int'(hm_pre), PIX_W));
    assign level  = cur_ge ? hm : lm;

    assign row       = {tile_r, idx[2*BLK_LOG2-1:BLK_LOG2]};
    assign col       = {tile_c, idx[BLK_LOG2-1:0]};
    assign out_we    = (state == S_WRITE);
    assign out_pix   = out_we ? {PIX_W'(0), level, PIX_W'(0)} : '0;
    assign state_dbg = state;

    ambtc_seq_div #(.NUM_W(NW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .quot     (quot),
        .busy     (div_busy),
        .done     (div_done)
    );

    // Handshake: start is sampled only in IDLE; busy is high from the accepting
    // edge until the edge that raises done; done then holds until the next accept.
    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_READ;
            S_READ:  if (idx == IW'(N)) state_nx = S_MEAN;
            S_MEAN:  state_nx = S_DEV;
            S_DEV:   if (idx == IW'(N - 1))
                         state_nx = (beta_next == IW'(N)) ? S_WRITE : S_DIV_L;
            S_DIV_L: begin
                div_start = !div_busy;
                if (div_done) state_nx = S_DIV_H;
            end
            S_DIV_H: begin
                div_start = !div_busy;
                if (div_done) state_nx = S_WRITE;
            end
            S_WRITE: if (idx == IW'(N - 1)) state_nx = S_NEXT;
            S_NEXT:  state_nx = last_tile ? S_FIN : S_READ;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (state == S_READ && idx != '0) tile_buf[idx_m1[IW-2:0]] <= pix_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_r <= '0;
            tile_c <= '0;
            idx    <= '0;
            mode_q <= 1'b0;
            sum    <= '0;
            acc    <= '0;
            beta   <= '0;
            avg    <= '0;
            lm     <= '0;
            uniform <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    mode_q <= mode;
                    busy   <= 1'b1;
                    done   <= 1'b0;
                    tile_r <= '0;
                    tile_c <= '0;
                    idx    <= '0;
                    sum    <= '0;
                end
                S_READ: begin
                    idx <= (idx == IW'(N)) ? '0 : idx + IW'(1);
                    if (idx != '0) sum <= sum + NW'(pix_val);
                end
                S_MEAN: begin
                    avg  <= sum[NW-1:2*BLK_LOG2];
                    acc  <= '0;
                    beta <= '0;
                    idx  <= '0;
                end
                S_DEV: begin
                    acc  <= acc + NW'(abs_diff);
                    beta <= beta_next;
                    if (idx == IW'(N - 1)) begin
                        idx     <= '0;
                        uniform <= (beta_next == IW'(N));
                        lm      <= avg;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DIV_H: if (!div_busy) lm <= PIX_W'(clamp(int'(lm_pre), PIX_W));
                S_WRITE: idx <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
                S_NEXT: begin
                    idx <= '0;
                    sum <= '0;
                    if (tile_c == '1) begin
                        tile_c <= '0;
                        tile_r <= tile_r + TW'(1);
                    end else begin
                        tile_c <= tile_c + TW'(1);
                    end
                end
                S_FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ambtc_block_coder.sv
// Bench for ambtc_block_coder: pixel-memory responder, write scoreboard fed by
// an arithmetic tile model, directed passes with randomized image content.
module tb_ambtc_block_coder;
    import ambtc_pkg::*;

    localparam int IMG_LOG2 = 6;
    localparam int BLK_LOG2 = 2;
    localparam int PIX_W    = 8;
    localparam int SIDE     = 1 << IMG_LOG2;
    localparam int BS       = 1 << BLK_LOG2;
    localparam int N        = BS * BS;
    localparam int TPR      = SIDE / BS;
    localparam int PMAX     = (1 << PIX_W) - 1;
    localparam int D        = PIX_W + 2 * BLK_LOG2 + 1;
    localparam int T_FULL   = (N + 1) + 1 + N + 2 * D + N + 1;
    localparam int T_UNI    = T_FULL - 2 * D;
    localparam int EW       = 2 * IMG_LOG2 + 3 * PIX_W;
    localparam int BUDGET   = 30000;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                mode;
    logic [3*PIX_W-1:0]  in_pix;
    logic [IMG_LOG2-1:0] row, col;
    logic                out_we;
    logic [3*PIX_W-1:0]  out_pix;
    logic                busy, done;
    state_e              state_dbg;

    ambtc_block_coder #(.IMG_LOG2(IMG_LOG2), .BLK_LOG2(BLK_LOG2), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_pix(in_pix),
        .row(row), .col(col), .out_we(out_we), .out_pix(out_pix),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- image memory and write monitor ----------------
    logic [PIX_W-1:0]    img_r [SIDE][SIDE];
    logic [PIX_W-1:0]    img_g [SIDE][SIDE];
    logic [PIX_W-1:0]    img_b [SIDE][SIDE];
    logic [3*PIX_W-1:0]  out_img [SIDE][SIDE];
    logic [IMG_LOG2-1:0] rd_r, rd_c;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_w, exp_w, first_obs, first_exp;
    int checks = 0;
    int errors = 0;
    int sb_bad = 0;
    int wr_cnt = 0;
    int exp_cycles = 0;

    always @(negedge clk) begin
        rd_r <= row;
        rd_c <= col;
    end

    always @(posedge clk) in_pix <= {img_r[rd_r][rd_c], img_g[rd_r][rd_c], img_b[rd_r][rd_c]};

    always @(negedge clk) begin
        if (rst_n && out_we) begin
            wr_cnt = wr_cnt + 1;
            out_img[row][col] = out_pix;
            obs_w = {row, col, out_pix};
            if (exp_q.size() == 0) begin
                sb_bad = sb_bad + 1;
            end else begin
                exp_w = exp_q.pop_front();
                if (obs_w !== exp_w) begin
                    if (sb_bad == 0) begin
                        first_obs = obs_w;
                        first_exp = exp_w;
                    end
                    sb_bad = sb_bad + 1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gray_ref(input int r, input int g, input int b);
        int vals[3];
        vals[0] = r; vals[1] = g; vals[2] = b;
        vals.sort();
        return (vals[0] + vals[2]) / 2;
    endfunction

    function automatic int lim(input int v);
        return (v < 0) ? 0 : (v > PMAX) ? PMAX : v;
    endfunction

    // Tile-level model: mean, mean absolute deviation, bitmap count, two levels.
    task automatic build_model(input bit m);
        int p[N];
        int sum, avg, acc, dv, beta, lm, hm, r, c;
        exp_q.delete();
        exp_cycles = 1;
        for (int tr = 0; tr < TPR; tr++) begin
            for (int tc = 0; tc < TPR; tc++) begin
                sum = 0;
                for (int k = 0; k < N; k++) begin
                    r = tr * BS + k / BS;
                    c = tc * BS + k % BS;
                    p[k] = m ? gray_ref(int'(img_r[r][c]), int'(img_g[r][c]), int'(img_b[r][c]))
                             : int'(img_g[r][c]);
                    sum += p[k];
                end
                avg = sum / N;
                acc = 0;
                beta = 0;
                for (int k = 0; k < N; k++) begin
                    acc += (p[k] >= avg) ? p[k] - avg : avg - p[k];
                    if (p[k] >= avg) beta++;
                end
                dv = acc / N;
                if (beta == N) begin
                    lm = avg;
                    hm = avg;
                    exp_cycles += T_UNI;
                end else begin
                    lm = lim(avg - (N * dv) / (2 * (N - beta)));
                    hm = lim(avg + (N * dv) / (2 * beta));
                    exp_cycles += T_FULL;
                end
                for (int k = 0; k < N; k++) begin
                    r = tr * BS + k / BS;
                    c = tc * BS + k % BS;
                    exp_q.push_back({IMG_LOG2'(r), IMG_LOG2'(c), PIX_W'(0),
                                     PIX_W'((p[k] >= avg) ? hm : lm), PIX_W'(0)});
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic fill_mixed();
        bit uni;
        logic [PIX_W-1:0] br, bg, bb;
        int r, c;
        for (int tr = 0; tr < TPR; tr++) begin
            for (int tc = 0; tc < TPR; tc++) begin
                uni = 1'($urandom_range(1, 0));
                br = PIX_W'($urandom_range(PMAX, 0));
                bg = PIX_W'($urandom_range(PMAX, 0));
                bb = PIX_W'($urandom_range(PMAX, 0));
                for (int k = 0; k < N; k++) begin
                    r = tr * BS + k / BS;
                    c = tc * BS + k % BS;
                    img_r[r][c] = uni ? br : PIX_W'($urandom_range(PMAX, 0));
                    img_g[r][c] = uni ? bg : PIX_W'($urandom_range(PMAX, 0));
                    img_b[r][c] = uni ? bb : PIX_W'($urandom_range(PMAX, 0));
                end
            end
        end
    endtask

    task automatic count_not(input logic [3*PIX_W-1:0] want, input string tag);
        int bad = 0;
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++)
                if (out_img[r][c] !== want) bad++;
        check(tag, bad, 0);
    endtask

    task automatic start_pass(input bit m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_pass(input bit m, input bit poke, input string tag);
        int cyc;
        bit got;
        build_model(m);
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++)
                out_img[r][c] = '1;
        wr_cnt = 0;
        sb_bad = 0;
        start_pass(m);
        check({tag, "_busy_on_accept"}, busy, 1);
        check({tag, "_done_cleared"}, done, 0);
        cyc = 0;
        got = 0;
        while (cyc < BUDGET && !got) begin
            @(posedge clk);
            cyc++;
            #1;
            if (poke) start = (cyc == 1000);
            if (done) got = 1;
        end
        start = 1'b0;
        check({tag, "_cycles_to_done"}, cyc, exp_cycles);
        check({tag, "_busy_low_at_done"}, busy, 0);
        check({tag, "_idle_at_done"}, state_dbg, S_IDLE);
        check({tag, "_write_count"}, wr_cnt, SIDE * SIDE);
        if (sb_bad != 0) $display("%s first bad write obs=%h exp=%h", tag, first_obs, first_exp);
        check({tag, "_scoreboard_bad"}, sb_bad, 0);
        check({tag, "_scoreboard_left"}, exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_row", row, 0);
        check("reset_col", col, 0);
        check("reset_we", out_we, 0);
        check("reset_pix", out_pix, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", state_dbg, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // Uniform G=0x80 image, mode 0, with a start pulse mid-pass.
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++) begin
                img_r[r][c] = PIX_W'($urandom_range(PMAX, 0));
                img_g[r][c] = 8'h80;
                img_b[r][c] = PIX_W'($urandom_range(PMAX, 0));
            end
        run_pass(0, 1, "uni80");
        check("uni80_cycle_formula", exp_cycles, TPR * TPR * 51 + 1);
        count_not(24'h008000, "uni80_words");

        // Mixed image, mode 0, with the two worked tiles at origin.
        fill_mixed();
        for (int k = 0; k < N; k++) begin
            img_g[k / BS][k % BS]      = (k % 2 == 0) ? 8'd10 : 8'd30;
            img_g[k / BS][BS + k % BS] = (k == 6) ? 8'd160 : 8'd0;
        end
        run_pass(0, 0, "mixed_m0");
        for (int k = 0; k < N; k++) begin
            check("tile_10_30", out_img[k / BS][k % BS], (k % 2 == 0) ? 24'h000A00 : 24'h001E00);
            check("tile_0_160", out_img[k / BS][BS + k % BS], (k == 6) ? 24'h009A00 : 24'h000100);
        end

        // Mixed image, grayscale mode.
        fill_mixed();
        run_pass(1, 0, "mixed_m1");

        // Abort during the fourth tile's write phase.
        fill_mixed();
        build_model(0);
        wr_cnt = 0;
        sb_bad = 0;
        start_pass(0);
        cyc = 0;
        while (cyc < 5000 && wr_cnt < 3 * N + 5) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("abort_tile3_reached", wr_cnt >= 3 * N + 5, 1);
        check("abort_we_before", out_we, 1);
        rst_n = 1'b0;
        #1;
        check("abort_row", row, 0);
        check("abort_col", col, 0);
        check("abort_we", out_we, 0);
        check("abort_pix", out_pix, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_state", state_dbg, S_IDLE);
        check("abort_partial_writes", sb_bad, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fresh pass after abort: grayscale of R=0x20 G=0x80 B=0x40 is 0x50.
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++) begin
                img_r[r][c] = 8'h20;
                img_g[r][c] = 8'h80;
                img_b[r][c] = 8'h40;
            end
        run_pass(1, 0, "gray50");
        count_not(24'h005000, "gray50_words");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
